// File: rtl/word_mem_ctrl.sv
// Byte-addressed big-endian word memory with a zero-fill sequencer, per-byte write enables,
// a registered read with write-first forwarding, and a sticky access-error flag.
module word_mem_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int BYTE_WIDTH = 8,
    parameter int WORD_BYTES = 2
) (
    input  logic                             clock_i,
    input  logic                             reset_i,
    input  logic                             clear_start_i,
    output logic                             ready_o,
    input  logic                             wr_en_i,
    input  logic [ADDR_WIDTH-1:0]            wr_address_i,
    input  logic [WORD_BYTES*BYTE_WIDTH-1:0] wr_data_i,
    input  logic [WORD_BYTES-1:0]            wr_byte_en_i,
    input  logic                             rd_en_i,
    input  logic [ADDR_WIDTH-1:0]            rd_address_i,
    output logic [WORD_BYTES*BYTE_WIDTH-1:0] rd_data_o,
    output logic                             rd_valid_o,
    output logic                             access_err_o
);

    localparam int WORD  = WORD_BYTES * BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(DEPTH - WORD_BYTES);
    localparam logic [ADDR_WIDTH-1:0] CLR_STEP = ADDR_WIDTH'(WORD_BYTES);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   clr_ptr_q;
    logic                    ready_q;
    logic                    rd_valid_q;
    logic [WORD-1:0]         rd_data_q;
    logic                    access_err_q;
    logic [BYTE_WIDTH-1:0]   mem_q [DEPTH];

    logic                    wr_go;
    logic                    rd_go;
    logic [WORD-1:0]         rd_word_d;

    assign wr_go = wr_en_i & ready_q;
    assign rd_go = rd_en_i & ready_q;

    // Storage has no reset; the fill sequencer is what zeroes it.
    always_ff @(posedge clock_i) begin
        if (state_q == ST_CLEAR) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                mem_q[clr_ptr_q + ADDR_WIDTH'(k)] <= '0;
            end
        end else if (wr_go) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                if (wr_byte_en_i[WORD_BYTES-1-k]) begin
                    mem_q[wr_address_i + ADDR_WIDTH'(k)] <= wr_data_i[WORD-1-k*BYTE_WIDTH -: BYTE_WIDTH];
                end
            end
        end
    end

    // Write-first per byte: any enabled write byte landing on a read byte wins.
    always_comb begin
        logic [ADDR_WIDTH-1:0] rd_byte_addr;
        logic [BYTE_WIDTH-1:0] rd_byte;
        rd_word_d    = '0;
        rd_byte_addr = '0;
        rd_byte      = '0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            rd_byte_addr = rd_address_i + ADDR_WIDTH'(k);
            rd_byte      = mem_q[rd_byte_addr];
            for (int j = 0; j < WORD_BYTES; j++) begin
                if (wr_go && wr_byte_en_i[WORD_BYTES-1-j] &&
                    ((wr_address_i + ADDR_WIDTH'(j)) == rd_byte_addr)) begin
                    rd_byte = wr_data_i[WORD-1-j*BYTE_WIDTH -: BYTE_WIDTH];
                end
            end
            rd_word_d[WORD-1-k*BYTE_WIDTH -: BYTE_WIDTH] = rd_byte;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_CLEAR;
            clr_ptr_q    <= '0;
            ready_q      <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            access_err_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_go;
            if (rd_go) begin
                rd_data_q <= rd_word_d;
            end
            if ((rd_en_i | wr_en_i) & ~ready_q) begin
                access_err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (clear_start_i) begin
                        state_q   <= ST_CLEAR;
                        clr_ptr_q <= '0;
                        ready_q   <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_ptr_q == CLR_LAST) begin
                        state_q   <= ST_IDLE;
                        clr_ptr_q <= '0;
                        ready_q   <= 1'b1;
                    end else begin
                        clr_ptr_q <= clr_ptr_q + CLR_STEP;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o      = ready_q;
    assign rd_valid_o   = rd_valid_q;
    assign rd_data_o    = rd_data_q;
    assign access_err_o = access_err_q;

endmodule

// File: tb/tb_word_mem_ctrl.sv
// Scoreboard bench for word_mem_ctrl: a byte-array model predicts every read, the
// monitor pops predictions when rd_valid is seen.
module tb_word_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_start;
    logic        ready;
    logic        wr_en;
    logic [10:0] wr_address;
    logic [15:0] wr_data;
    logic [1:0]  wr_byte_en;
    logic        rd_en;
    logic [10:0] rd_address;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        access_err;

    int checks   = 0;
    int failures = 0;
    logic [7:0]  model [2048];
    logic [15:0] exp_q [$];

    word_mem_ctrl #(.ADDR_WIDTH(11), .BYTE_WIDTH(8), .WORD_BYTES(2)) dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .clear_start_i(clear_start),
        .ready_o      (ready),
        .wr_en_i      (wr_en),
        .wr_address_i (wr_address),
        .wr_data_i    (wr_data),
        .wr_byte_en_i (wr_byte_en),
        .rd_en_i      (rd_en),
        .rd_address_i (rd_address),
        .rd_data_o    (rd_data),
        .rd_valid_o   (rd_valid),
        .access_err_o (access_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input logic [10:0] a);
        logic [10:0] a1;
        a1 = a + 11'd1;
        return {model[a], model[a1]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle of accesses; write applied to the model first so reads see write-first data.
    task automatic access(input bit dw, input logic [10:0] wa, input logic [15:0] wd,
                          input logic [1:0] be, input bit dr, input logic [10:0] ra);
        logic [10:0] wa1;
        wa1        = wa + 11'd1;
        wr_en      = dw;
        wr_address = wa;
        wr_data    = wd;
        wr_byte_en = be;
        rd_en      = dr;
        rd_address = ra;
        if (dw) begin
            if (be[1]) model[wa]  = wd[15:8];
            if (be[0]) model[wa1] = wd[7:0];
        end
        if (dr) exp_q.push_back(exp_word(ra));
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (!ready && n < 3000) begin
            step();
            n++;
        end
        chk(tag, n, exp_cycles);
    endtask

    task automatic zero_model();
        for (int i = 0; i < 2048; i++) model[i] = 8'h00;
    endtask

    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) chk("unexpected_rd_valid", 1, 0);
            else chk("rd_data", rd_data, exp_q.pop_front());
        end
    end

    initial begin
        rst         = 1'b1;
        clear_start = 1'b0;
        wr_en       = 1'b0;
        wr_address  = '0;
        wr_data     = '0;
        wr_byte_en  = '0;
        rd_en       = 1'b0;
        rd_address  = '0;
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_access_err", access_err, 0);
        step();
        step();
        rst = 1'b0;
        zero_model();
        wait_ready("t1_fill_cycles", 1024);

        access(0, 0, 0, 0, 1, 11'h000);
        access(0, 0, 0, 0, 1, 11'h688);
        access(0, 0, 0, 0, 1, 11'h7FE);
        step();

        // Single-cycle read latency and valid pulse width.
        access(1, 11'h004, 16'h0507, 2'b11, 0, 0);
        access(0, 0, 0, 0, 1, 11'h004);
        chk("t2_valid_n1", rd_valid, 1);
        step();
        chk("t2_valid_n2", rd_valid, 0);

        // Wrap across the top of the array.
        access(1, 11'h7FF, 16'hABCD, 2'b11, 0, 0);
        access(0, 0, 0, 0, 1, 11'h7FF);
        access(0, 0, 0, 0, 1, 11'h000);

        // Partial-overlap read-during-write.
        access(1, 11'h248, 16'h1122, 2'b11, 0, 0);
        access(1, 11'h249, 16'h33CC, 2'b10, 1, 11'h248);
        access(0, 0, 0, 0, 1, 11'h248);
        access(0, 0, 0, 0, 1, 11'h249);
        access(1, 11'h100, 16'hBEEF, 2'b01, 1, 11'h100);
        access(1, 11'h101, 16'h7788, 2'b11, 1, 11'h100);
        step();

        // Fill on request; second request mid-fill must not restart it.
        access(1, 11'h300, 16'h5A5A, 2'b11, 0, 0);
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        zero_model();
        chk("t5_ready_low", ready, 0);
        access(0, 0, 0, 0, 0, 0);
        rd_en      = 1'b1;
        rd_address = 11'h300;
        step();
        rd_en = 1'b0;
        chk("t5_drop_valid", rd_valid, 0);
        chk("t5_access_err", access_err, 1);
        for (int i = 0; i < 8; i++) step();
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        wait_ready("t5_fill_cycles", 1024 - 11);
        access(0, 0, 0, 0, 1, 11'h300);
        access(0, 0, 0, 0, 1, 11'h7FF);
        access(0, 0, 0, 0, 1, 11'h248);
        access(0, 0, 0, 0, 1, 11'h004);
        step();
        chk("t5_err_sticky", access_err, 1);

        // Reset mid-fill restarts the fill and clears the error flag.
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        for (int i = 0; i < 500; i++) step();
        rst = 1'b1;
        #1;
        chk("t6_err_cleared", access_err, 0);
        chk("t6_ready_low", ready, 0);
        step();
        rst = 1'b0;
        wait_ready("t6_fill_cycles", 1024);
        chk("t6_err_after", access_err, 0);

        // Async reset kills an in-flight valid immediately.
        access(1, 11'h010, 16'hC3C3, 2'b11, 0, 0);
        rd_en      = 1'b1;
        rd_address = 11'h010;
        step();
        rd_en = 1'b0;
        chk("t6_rd_valid_pre", rd_valid, 1);
        rst = 1'b1;
        #1;
        chk("t6_rd_valid_reset", rd_valid, 0);
        chk("t6_rd_data_reset", rd_data, 0);
        step();
        rst = 1'b0;
        zero_model();
        wait_ready("t6_fill_cycles_2", 1024);
        access(0, 0, 0, 0, 1, 11'h010);
        step();
        step();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
